// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register index width, MDU sequencer states
// and the register-match helper used by the hazard equations.
package pipe_pkg;

    localparam int REG_W = 5;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    // Register 0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [REG_W-1:0] a,
                                       input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// MDU occupancy sequencer: loads a cycle count on start, counts down while
// busy, and flags the final busy cycle with a registered done.
module md_busy_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             done
);

    md_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= MD_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                MD_IDLE: begin
                    if (start) begin
                        state_reg <= MD_BUSY;
                        cnt_reg   <= len;
                        busy_reg  <= 1'b1;
                        done_reg  <= (len == CNT_W'(1));
                    end
                end
                MD_BUSY: begin
                    // Final busy cycle: return to idle; otherwise count down and
                    // pre-compute done for the cycle that will hold cnt==1.
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_reg <= MD_IDLE;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                    end else begin
                        cnt_reg  <= cnt_reg - CNT_W'(1);
                        done_reg <= (cnt_reg == CNT_W'(2));
                    end
                end
                default: begin
                    state_reg <= MD_IDLE;
                    cnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: rtl/hazard_controller.sv
// Hazard detection and stall/flush generation for the 5-stage core, covering
// load-use, branch-in-decode operand and MDU occupancy hazards.
module hazard_controller
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic [REG_W-1:0] rt_e,
    input  logic [REG_W-1:0] write_reg_e,
    input  logic [REG_W-1:0] write_reg_m,
    input  logic             reg_write_e,
    input  logic             mem_to_reg_e,
    input  logic             mem_to_reg_m,
    input  logic             branch_d,
    input  logic             md_op_d,
    input  logic             md_is_div_d,
    input  logic             hilo_read_d,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_done
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    logic             lw_stall;
    logic             br_stall;
    logic             md_stall;
    logic             hz;
    logic [CNT_W-1:0] md_len;

    assign lw_stall = mem_to_reg_e &
                      (reg_match(rt_e, rs_d) | reg_match(rt_e, rt_d));

    assign br_stall = branch_d &
                      ((reg_write_e  & (reg_match(write_reg_e, rs_d) | reg_match(write_reg_e, rt_d))) |
                       (mem_to_reg_m & (reg_match(write_reg_m, rs_d) | reg_match(write_reg_m, rt_d))));

    // md_busy is registered, so this term cannot form a loop through md_start.
    assign md_stall = md_busy & (md_op_d | hilo_read_d);

    assign hz       = lw_stall | br_stall | md_stall;
    assign stall_f  = hz;
    assign stall_d  = hz;
    assign flush_e  = hz;
    assign md_start = md_op_d & ~hz;

    assign md_len = md_is_div_d ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    md_busy_counter #(
        .CNT_W (CNT_W)
    ) u_md_busy_counter (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .len   (md_len),
        .busy  (md_busy),
        .done  (md_done)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized and directed checks of hazard_controller against a cycle-count
// reference model of MDU occupancy and the hazard rules.
module tb_hazard_controller;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rte;
        logic [4:0] wre;
        logic [4:0] wrm;
        logic       rwe;
        logic       mtre;
        logic       mtrm;
        logic       br;
        logic       op;
        logic       isdiv;
        logic       hilo;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs_d = '0, rt_d = '0, rt_e = '0, write_reg_e = '0, write_reg_m = '0;
    logic       reg_write_e = 0, mem_to_reg_e = 0, mem_to_reg_m = 0;
    logic       branch_d = 0, md_op_d = 0, md_is_div_d = 0, hilo_read_d = 0;
    logic       stall_f, stall_d, flush_e, md_start, md_busy, md_done;

    int n_vec = 0;
    int n_bad = 0;
    int remaining = 0;   // model: MDU busy cycles still ahead, including the current one

    always #5 clk = ~clk;

    hazard_controller #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .rt_e(rt_e),
        .write_reg_e(write_reg_e), .write_reg_m(write_reg_m),
        .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
        .mem_to_reg_m(mem_to_reg_m), .branch_d(branch_d), .md_op_d(md_op_d),
        .md_is_div_d(md_is_div_d), .hilo_read_d(hilo_read_d),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .md_start(md_start), .md_busy(md_busy), .md_done(md_done)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%b want=%b", tag, $time, obs, exp);
        end
    endtask

    function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
        return (a != 0) && (a == b);
    endfunction

    task automatic drive(input vec_t v);
        rs_d = v.rs; rt_d = v.rt; rt_e = v.rte; write_reg_e = v.wre; write_reg_m = v.wrm;
        reg_write_e = v.rwe; mem_to_reg_e = v.mtre; mem_to_reg_m = v.mtrm;
        branch_d = v.br; md_op_d = v.op; md_is_div_d = v.isdiv; hilo_read_d = v.hilo;
    endtask

    // Called just after a rising edge: apply, check mid-cycle, advance model.
    task automatic step(input vec_t v, input string name);
        bit lw, brs, mds, hz, st, busy, done;
        drive(v);
        @(negedge clk);
        lw   = v.mtre && (dep(v.rte, v.rs) || dep(v.rte, v.rt));
        brs  = v.br && ((v.rwe && (dep(v.wre, v.rs) || dep(v.wre, v.rt))) ||
                        (v.mtrm && (dep(v.wrm, v.rs) || dep(v.wrm, v.rt))));
        busy = remaining > 0;
        done = remaining == 1;
        mds  = busy && (v.op || v.hilo);
        hz   = lw || brs || mds;
        st   = v.op && !hz;
        check({name, ".stall_f"}, stall_f, hz);
        check({name, ".stall_d"}, stall_d, hz);
        check({name, ".flush_e"}, flush_e, hz);
        check({name, ".md_start"}, md_start, st);
        check({name, ".md_busy"}, md_busy, busy);
        check({name, ".md_done"}, md_done, done);
        $display("%s rs=%0d rt=%0d op=%b div=%b hilo=%b rem=%0d -> hz=%b start=%b busy=%b done=%b",
                 name, v.rs, v.rt, v.op, v.isdiv, v.hilo, remaining, stall_f, md_start, md_busy, md_done);
        if (st)
            remaining = v.isdiv ? DIV_N : MULT_N;
        else if (remaining > 0)
            remaining--;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t nop();
        vec_t v;
        v = '0;
        return v;
    endfunction

    initial begin
        vec_t v;

        #1;
        check("rst.stall_f", stall_f, 1'b0);
        check("rst.flush_e", flush_e, 1'b0);
        check("rst.md_start", md_start, 1'b0);
        check("rst.md_busy", md_busy, 1'b0);
        check("rst.md_done", md_done, 1'b0);
        #11 rst = 1'b0;
        @(posedge clk);
        #1;

        // Load-use: one stall, then the bubble clears it; r0 never matches.
        v = nop(); v.mtre = 1; v.rte = 5; v.rs = 5; step(v, "lw_use");
        v = nop(); v.rs = 5; step(v, "lw_after");
        v = nop(); v.mtre = 1; v.rte = 0; v.rs = 0; step(v, "lw_r0");

        // Branch on r8: load in EX, then in MEM, then clear; ALU producer.
        v = nop(); v.br = 1; v.rs = 8; v.mtre = 1; v.rte = 8; v.rwe = 1; v.wre = 8; step(v, "br_ld_e");
        v = nop(); v.br = 1; v.rs = 8; v.mtrm = 1; v.wrm = 8; step(v, "br_ld_m");
        v = nop(); v.br = 1; v.rs = 8; step(v, "br_go");
        v = nop(); v.br = 1; v.rs = 8; v.rwe = 1; v.wre = 8; step(v, "br_alu");
        v = nop(); v.br = 1; v.rs = 8; step(v, "br_alu_go");

        // Multiply then mflo held for the full multiply.
        v = nop(); v.op = 1; step(v, "mult");
        for (int i = 0; i < MULT_N + 1; i++) begin
            v = nop(); v.hilo = 1; step(v, "mflo");
        end

        // Back-to-back divides: the second waits out the first.
        v = nop(); v.op = 1; v.isdiv = 1; step(v, "div1");
        for (int i = 0; i < DIV_N + 1; i++) begin
            v = nop(); v.op = 1; v.isdiv = 1; step(v, "div2");
        end
        for (int i = 0; i < DIV_N; i++) step(nop(), "drain");

        // MDU op collides with a load-use stall, then retries.
        v = nop(); v.op = 1; v.mtre = 1; v.rte = 3; v.rt = 3; step(v, "md_lw");
        v = nop(); v.op = 1; v.rt = 3; step(v, "md_retry");
        for (int i = 0; i < MULT_N; i++) step(nop(), "drain");

        // Reset in the middle of a divide.
        v = nop(); v.op = 1; v.isdiv = 1; step(v, "div_rst");
        for (int i = 0; i < 9; i++) step(nop(), "div_run");
        drive(nop());
        #2 rst = 1'b1;
        #1;
        check("arst.md_busy", md_busy, 1'b0);
        check("arst.md_done", md_done, 1'b0);
        $display("async reset mid-divide busy=%b done=%b", md_busy, md_done);
        remaining = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        v = nop(); v.hilo = 1; step(v, "mflo_post_rst");

        // Randomized traffic with a small register range to provoke matches.
        for (int i = 0; i < 600; i++) begin
            v.rs    = 5'($urandom_range(0, 3));
            v.rt    = 5'($urandom_range(0, 3));
            v.rte   = 5'($urandom_range(0, 3));
            v.wre   = 5'($urandom_range(0, 3));
            v.wrm   = 5'($urandom_range(0, 3));
            v.rwe   = 1'($urandom_range(0, 1));
            v.mtre  = ($urandom_range(0, 3) == 0);
            v.mtrm  = ($urandom_range(0, 3) == 0);
            v.br    = ($urandom_range(0, 3) == 0);
            v.op    = ($urandom_range(0, 5) == 0);
            v.isdiv = ($urandom_range(0, 3) == 0);
            v.hilo  = ($urandom_range(0, 3) == 0);
            step(v, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It works alongside the `data_forward` unit and handles the hazards forwarding cannot cover:
- load-use hazards;
- branch-in-decode operands that are not yet available;
- occupancy of the multi-cycle multiply/divide unit (MDU).

It drives the stall and flush enables of the IF/ID and ID/EX pipeline registers. It also owns the MDU busy counter, which sequences MDU launches and HI/LO reads.

## Interface
Parameters:
- `MULT_CYCLES`, default 4: busy cycles for mult/multu. Must be ≥1.
- `DIV_CYCLES`, default 32: busy cycles for div/divu. Must satisfy `MULT_CYCLES` ≤ `DIV_CYCLES`.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rs_d`, `rt_d` in 5: decode-stage source registers.
- `rt_e` in 5: execute-stage rt.
- `write_reg_e`, `write_reg_m` in 5: destination registers in EX and MEM.
- `reg_write_e` in 1: EX instruction writes the register file.
- `mem_to_reg_e`, `mem_to_reg_m` in 1: EX/MEM instruction is a load.
- `branch_d` in 1: decode holds a beq/bne/jr that compares or uses registers in ID.
- `md_op_d` in 1: decode holds mult/multu/div/divu.
- `md_is_div_d` in 1: qualifies `md_op_d`; 1 = divide.
- `hilo_read_d` in 1: decode holds mfhi/mflo.
- `stall_f` out 1: hold PC.
- `stall_d` out 1: hold IF/ID.
- `flush_e` out 1: clear ID/EX (insert bubble).
- `md_start` out 1: one-cycle launch pulse to the MDU.
- `md_busy` out 1: MDU occupied (registered).
- `md_done` out 1: final busy cycle (registered).

## Operation
Hazard terms. All comparisons exclude register 0.
- `lw_stall` = `mem_to_reg_e` & (`rt_e`==`rs_d` | `rt_e`==`rt_d`).
- `br_stall` = `branch_d` & one of the following, each matched against `rs_d` or `rt_d`:
  - `reg_write_e` & `write_reg_e` matches;
  - `mem_to_reg_m` & `write_reg_m` matches.
- `md_stall` = `md_busy` & (`md_op_d` | `hilo_read_d`).
- `hz` = `lw_stall` | `br_stall` | `md_stall`.
- `stall_f` = `stall_d` = `flush_e` = `hz`. These are combinational and are zero when all inputs are zero.
- `md_start` = `md_op_d` & ~`hz`. It is combinational. It can only be 1 in IDLE, because `md_stall` blocks it when busy.

FSM states:
- IDLE:
  - `md_busy`=0, `cnt`=0.
  - On `md_start`, go to BUSY and load `cnt` = `md_is_div_d` ? `DIV_CYCLES` : `MULT_CYCLES`.
- BUSY:
  - `md_busy`=1.
  - `cnt` decrements each cycle.
  - When `cnt`==1, `md_done`=1 for that cycle. On the next edge go to IDLE with `cnt`=0.

Counter width is `$clog2(DIV_CYCLES+1)`. The counter never wraps: the decrement is gated to BUSY and `cnt`≥1.

Boundary rules:
- `md_op_d` or `hilo_read_d` arriving in the final BUSY cycle (`md_done`=1) still stalls. It proceeds in the following IDLE cycle.
- `md_op_d` together with `lw_stall` or `br_stall`: no launch. The op retries when the stall clears.
- `rst` during BUSY: the state, `cnt`, `md_busy` and `md_done` clear immediately. The launched MDU operation is abandoned.

## Timing
- Reset values: IDLE, `cnt`=0, `md_busy`=0, `md_done`=0. Combinational outputs follow their inputs.
- Stall/flush latency is 0 cycles, same-cycle combinational, so the pipeline registers capture it at the next edge.
- `md_start` in cycle T gives:
  - `md_busy`=1 in cycles T+1 … T+N, where N = `MULT_CYCLES` or `DIV_CYCLES`;
  - `md_done`=1 in cycle T+N;
  - IDLE at T+N+1.
- A dependent mfhi/mflo issued at T+1 stalls for N cycles and leaves decode at T+N+1.
- A load-use stall lasts exactly 1 cycle.
- A branch stall lasts:
  - 1 cycle for an ALU producer in EX;
  - 2 cycles for a load producer in EX.

## Structure
- Shared package `pipe_pkg` holds:
  - state enum `md_state_t` {MD_IDLE, MD_BUSY};
  - register-index width constant `REG_W`=5.
- One natural sub-module, `md_busy_counter`: the FSM plus the down-counter. It has load/start/len inputs and busy/done outputs.
- The hazard equations stay in the top level.

## Test plan
- Load-use: `mem_to_reg_e`=1, `rt_e`=5, `rs_d`=5 → `stall_f`=`stall_d`=`flush_e`=1 for exactly one cycle. With `rt_e`=0 and `rs_d`=0 → no stall.
- Branch after load: `branch_d`=1, `rs_d`=8.
  - Load to r8 in EX, then in MEM → stall for 2 consecutive cycles.
  - ALU write to r8 in EX → 1 cycle.
- Multiply then mflo: `md_op_d`=1, `md_is_div_d`=0 at T → `md_start`=1 at T; `md_busy` high T+1..T+4; `md_done` at T+4. `hilo_read_d` at T+1 → stall T+1..T+4, released at T+5.
- Divide back-to-back: div at T, second div at T+1 → second held 32 cycles; its `md_start` fires at T+33.
- Simultaneous: `md_op_d` together with `lw_stall` → `md_start`=0 that cycle, `md_start`=1 the next cycle.
- Reset mid-divide: assert `rst` at T+10 → `md_busy`=0 and `md_done`=0 asynchronously. After release, an mflo does not stall.
